// File: rtl/hvgen_param.sv
// hvgen_param: parametrised raster timing generator.
// Generates pixel position, blanking, sync, DE and line/frame strobes from
// clk_sys qualified by ce_pix. Blanks the core's RGB and applies a per-frame
// signed centring adjust to the horizontal and vertical sync positions.
module hvgen_param #(
    parameter int H_ACTIVE = 256,
    parameter int H_FP     = 39,
    parameter int H_SYNC   = 32,
    parameter int H_BP     = 57,
    parameter int V_ACTIVE = 224,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 7,
    parameter int V_BP     = 29,
    parameter int H_LEAD   = 0,
    parameter int POS_W    = 9,
    parameter int RGB_W    = 8,
    parameter int HS_POL   = 0,
    parameter int VS_POL   = 0
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic             ce_pix,
    input  logic [3:0]       h_adj,
    input  logic [3:0]       v_adj,
    input  logic [RGB_W-1:0] iRGB,
    output logic [POS_W-1:0] HPOS,
    output logic [POS_W-1:0] VPOS,
    output logic [RGB_W-1:0] oRGB,
    output logic             HBLK,
    output logic             VBLK,
    output logic             HSYN,
    output logic             VSYN,
    output logic             DE,
    output logic             LINE_STB,
    output logic             FRAME_STB,
    output logic [7:0]       frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Asserted level of each sync output.
    localparam logic HS_ON = (HS_POL != 0);
    localparam logic VS_ON = (VS_POL != 0);

    // Raster counters and the adjust values in force for the current frame.
    logic [POS_W-1:0]  r_hcnt;
    logic [POS_W-1:0]  r_vcnt;
    logic signed [3:0] r_hadj;
    logic signed [3:0] r_vadj;

    // Registered outputs.
    logic              r_hblk;
    logic              r_vblk;
    logic              r_hsyn;
    logic              r_vsyn;
    logic              r_de;
    logic [RGB_W-1:0]  r_rgb;
    logic              r_line_stb;
    logic              r_frame_stb;
    logic [7:0]        r_frame_cnt;

    // Decode of the current counter values.
    int                w_hcnt_i;
    int                w_vcnt_i;
    int                w_hfp;
    int                w_vfp;
    logic              w_h_act;
    logic              w_v_act;
    logic              w_hs_act;
    logic              w_vs_act;
    logic              w_de;

    // Counter advance.
    logic              w_h_wrap;
    logic              w_v_wrap;
    logic              w_v_bad;
    logic              w_frame_wrap;
    logic [POS_W-1:0]  w_hcnt_next;
    logic [POS_W-1:0]  w_vcnt_next;

    // Effective front porch: the adjusted value may neither go negative nor
    // push the sync pulse past the end of the line/frame.
    function automatic int clamp_porch(input int value, input int hi);
        if (value < 0) begin
            return 0;
        end else if (value > hi) begin
            return hi;
        end
        return value;
    endfunction

    // Position outputs come straight from the counters; HPOS may run ahead.
    assign HPOS      = r_hcnt + POS_W'(H_LEAD);
    assign VPOS      = r_vcnt;
    assign oRGB      = r_rgb;
    assign HBLK      = r_hblk;
    assign VBLK      = r_vblk;
    assign HSYN      = r_hsyn;
    assign VSYN      = r_vsyn;
    assign DE        = r_de;
    assign LINE_STB  = r_line_stb;
    assign FRAME_STB = r_frame_stb;
    assign frame_cnt = r_frame_cnt;

    // Blanking and sync decode of the present raster position.
    always_comb begin
        w_hcnt_i = int'(r_hcnt);
        w_vcnt_i = int'(r_vcnt);
        w_hfp    = clamp_porch(H_FP + int'(r_hadj), H_FP + H_BP - 1);
        w_vfp    = clamp_porch(V_FP + int'(r_vadj), V_FP + V_BP - 1);
        w_h_act  = (w_hcnt_i < H_ACTIVE);
        w_v_act  = (w_vcnt_i < V_ACTIVE);
        w_hs_act = (w_hcnt_i >= H_ACTIVE + w_hfp) &&
                   (w_hcnt_i <  H_ACTIVE + w_hfp + H_SYNC);
        w_vs_act = (w_vcnt_i >= V_ACTIVE + w_vfp) &&
                   (w_vcnt_i <  V_ACTIVE + w_vfp + V_SYNC);
        w_de     = w_h_act && w_v_act;
    end

    // Next counter values; out-of-range values fall back to 0 on the next ce.
    always_comb begin
        w_h_wrap     = (w_hcnt_i >= H_TOTAL - 1);
        w_v_wrap     = (w_vcnt_i >= V_TOTAL - 1);
        w_v_bad      = (w_vcnt_i >= V_TOTAL);
        w_frame_wrap = w_h_wrap && w_v_wrap;
        w_hcnt_next  = w_h_wrap ? '0 : r_hcnt + 1'b1;
        w_vcnt_next  = r_vcnt;
        if (w_h_wrap) begin
            w_vcnt_next = w_v_wrap ? '0 : r_vcnt + 1'b1;
        end else if (w_v_bad) begin
            w_vcnt_next = '0;
        end
    end

    // Raster counters and per-frame adjust latch.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hcnt <= POS_W'(H_ACTIVE);
            r_vcnt <= POS_W'(V_ACTIVE);
            r_hadj <= '0;
            r_vadj <= '0;
        end else if (ce_pix) begin
            r_hcnt <= w_hcnt_next;
            r_vcnt <= w_vcnt_next;
            if (w_frame_wrap) begin
                r_hadj <= $signed(h_adj);
                r_vadj <= $signed(v_adj);
            end
        end
    end

    // Registered video outputs, one ce behind the counters.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_hblk <= 1'b1;
            r_vblk <= 1'b1;
            r_hsyn <= ~HS_ON;
            r_vsyn <= ~VS_ON;
            r_de   <= 1'b0;
            r_rgb  <= '0;
        end else if (ce_pix) begin
            r_hblk <= ~w_h_act;
            r_vblk <= ~w_v_act;
            r_hsyn <= w_hs_act ? HS_ON : ~HS_ON;
            r_vsyn <= w_vs_act ? VS_ON : ~VS_ON;
            r_de   <= w_de;
            r_rgb  <= w_de ? iRGB : '0;
        end
    end

    // Line/frame strobes last one clk_sys; the frame counter moves with them.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_line_stb  <= 1'b0;
            r_frame_stb <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_line_stb  <= ce_pix && w_h_wrap;
            r_frame_stb <= ce_pix && w_frame_wrap;
            if (ce_pix && w_frame_wrap) begin
                r_frame_cnt <= r_frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_hvgen_param.sv
// Testbench for hvgen_param: a default-geometry instance and a small-geometry
// instance run against a linear-index raster model, plus directed timing checks.
module tb_hvgen_param;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       ce0, ce1;
    logic [3:0] hadj0, vadj0, hadj1, vadj1;
    logic [7:0] irgb0, irgb1;

    logic [8:0] hpos0, vpos0;
    logic [7:0] orgb0, fc0;
    logic       hblk0, vblk0, hs0, vs0, de0, ls0, fs0;
    logic [5:0] hpos1, vpos1;
    logic [7:0] orgb1, fc1;
    logic       hblk1, vblk1, hs1, vs1, de1, ls1, fs1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hvgen_param u_def (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce0), .h_adj(hadj0), .v_adj(vadj0),
        .iRGB(irgb0), .HPOS(hpos0), .VPOS(vpos0), .oRGB(orgb0), .HBLK(hblk0), .VBLK(vblk0),
        .HSYN(hs0), .VSYN(vs0), .DE(de0), .LINE_STB(ls0), .FRAME_STB(fs0), .frame_cnt(fc0)
    );

    hvgen_param #(
        .H_ACTIVE(32), .H_FP(5), .H_SYNC(4), .H_BP(7),
        .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(4), .POS_W(6)
    ) u_small (
        .clk_sys(clk), .reset_n(reset_n), .ce_pix(ce1), .h_adj(hadj1), .v_adj(vadj1),
        .iRGB(irgb1), .HPOS(hpos1), .VPOS(vpos1), .oRGB(orgb1), .HBLK(hblk1), .VBLK(vblk1),
        .HSYN(hs1), .VSYN(vs1), .DE(de1), .LINE_STB(ls1), .FRAME_STB(fs1), .frame_cnt(fc1)
    );

    // Geometry of each instance (0 = default, 1 = small).
    function automatic int p_ha(int d); return (d == 0) ? 256 : 32; endfunction
    function automatic int p_hf(int d); return (d == 0) ? 39 : 5;   endfunction
    function automatic int p_hs(int d); return (d == 0) ? 32 : 4;   endfunction
    function automatic int p_hb(int d); return (d == 0) ? 57 : 7;   endfunction
    function automatic int p_va(int d); return (d == 0) ? 224 : 20; endfunction
    function automatic int p_vf(int d); return 3;                   endfunction
    function automatic int p_vs(int d); return (d == 0) ? 7 : 2;    endfunction
    function automatic int p_vb(int d); return (d == 0) ? 29 : 4;   endfunction
    function automatic int ht(int d); return p_ha(d) + p_hf(d) + p_hs(d) + p_hb(d); endfunction
    function automatic int vt(int d); return p_va(d) + p_vf(d) + p_vs(d) + p_vb(d); endfunction

    function automatic int clampi(int x, int lo, int hi);
        return (x < lo) ? lo : ((x > hi) ? hi : x);
    endfunction

    // Model: raster position as a linear index into the frame.
    int m_p[2], m_hl[2], m_vl[2], m_fc[2], e_rgb[2];
    bit e_hblk[2], e_vblk[2], e_hs[2], e_vs[2], e_de[2], e_ls[2], e_fs[2];

    // Measurements, updated on each enabled cycle.
    int ce_total[2], ce_ls[2], gap[2], first_gap[2], got_first[2], fs_ce[2];
    int hb_acc[2], hb_line[2], hfall[2], hs_run[2], hs_len[2], vfall[2];
    int vs_acc[2], vs_lines[2], ln_acc[2], ln_frame[2], de_acc[2], de_frame[2];
    bit prev_hs[2], prev_vs[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_p[d] = p_va(d) * ht(d) + p_ha(d);
            m_hl[d] = 0; m_vl[d] = 0; m_fc[d] = 0; e_rgb[d] = 0;
            e_hblk[d] = 1; e_vblk[d] = 1; e_hs[d] = 1; e_vs[d] = 1;
            e_de[d] = 0; e_ls[d] = 0; e_fs[d] = 0;
        end
    endtask

    task automatic meas_reset();
        for (int d = 0; d < 2; d++) begin
            ce_total[d] = 0; ce_ls[d] = 0; gap[d] = 0; first_gap[d] = 0; got_first[d] = 0;
            fs_ce[d] = 0; hb_acc[d] = 0; hb_line[d] = 0; hfall[d] = -1; hs_run[d] = 0;
            hs_len[d] = 0; vfall[d] = -1; vs_acc[d] = 0; vs_lines[d] = 0; ln_acc[d] = 0;
            ln_frame[d] = 0; de_acc[d] = 0; de_frame[d] = 0; prev_hs[d] = 1; prev_vs[d] = 1;
        end
    endtask

    task automatic model_ce(int d, int irgb, int hadj, int vadj);
        int h, v, hfp, vfp;
        h = m_p[d] % ht(d);
        v = m_p[d] / ht(d);
        hfp = clampi(p_hf(d) + m_hl[d], 0, p_hf(d) + p_hb(d) - 1);
        vfp = clampi(p_vf(d) + m_vl[d], 0, p_vf(d) + p_vb(d) - 1);
        e_hblk[d] = (h >= p_ha(d));
        e_vblk[d] = (v >= p_va(d));
        e_hs[d] = !(h >= p_ha(d) + hfp && h < p_ha(d) + hfp + p_hs(d));
        e_vs[d] = !(v >= p_va(d) + vfp && v < p_va(d) + vfp + p_vs(d));
        e_de[d] = !e_hblk[d] && !e_vblk[d];
        e_rgb[d] = e_de[d] ? irgb : 0;
        m_p[d] = (m_p[d] + 1) % (ht(d) * vt(d));
        e_ls[d] = (m_p[d] % ht(d)) == 0;
        e_fs[d] = (m_p[d] == 0);
        if (e_fs[d]) begin
            m_fc[d] = (m_fc[d] + 1) % 256;
            m_hl[d] = hadj;
            m_vl[d] = vadj;
        end
    endtask

    function automatic logic [40:0] obs_vec(int d);
        if (d == 0)
            return {hpos0, vpos0, orgb0, hblk0, vblk0, hs0, vs0, de0, ls0, fs0, fc0};
        return {3'b000, hpos1, 3'b000, vpos1, orgb1, hblk1, vblk1, hs1, vs1, de1, ls1, fs1, fc1};
    endfunction

    function automatic logic [40:0] exp_vec(int d);
        int h, v;
        h = m_p[d] % ht(d);
        v = m_p[d] / ht(d);
        return {9'(h), 9'(v), 8'(e_rgb[d]), e_hblk[d], e_vblk[d], e_hs[d], e_vs[d],
                e_de[d], e_ls[d], e_fs[d], 8'(m_fc[d])};
    endfunction

    task automatic check_vec(string tag, logic [40:0] obs, logic [40:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, expv);
        end
    endtask

    task automatic checki(string tag, int obs, int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, expv);
        end
    endtask

    task automatic meas(int d);
        int hp, vp;
        bit hb, hs, vs, de, ls, fs;
        if (d == 0) begin
            hp = int'(hpos0); vp = int'(vpos0); hb = hblk0; hs = hs0; vs = vs0;
            de = de0; ls = ls0; fs = fs0;
        end else begin
            hp = int'(hpos1); vp = int'(vpos1); hb = hblk1; hs = hs1; vs = vs1;
            de = de1; ls = ls1; fs = fs1;
        end
        ce_total[d]++;
        ce_ls[d]++;
        if (!hb) hb_acc[d]++;
        if (de) de_acc[d]++;
        if (prev_hs[d] && !hs) begin hfall[d] = hp; hs_run[d] = 0; end
        if (!hs) hs_run[d]++;
        if (!prev_hs[d] && hs) hs_len[d] = hs_run[d];
        if (prev_vs[d] && !vs) vfall[d] = vp;
        prev_hs[d] = hs;
        prev_vs[d] = vs;
        if (ls) begin
            gap[d] = ce_ls[d];
            if (got_first[d] == 0) begin first_gap[d] = gap[d]; got_first[d] = 1; end
            ce_ls[d] = 0;
            hb_line[d] = hb_acc[d];
            hb_acc[d] = 0;
            ln_acc[d]++;
            if (!vs) vs_acc[d]++;
        end
        if (fs) begin
            if (fs_ce[d] == 0) fs_ce[d] = ce_total[d];
            ln_frame[d] = ln_acc[d]; ln_acc[d] = 0;
            de_frame[d] = de_acc[d]; de_acc[d] = 0;
            vs_lines[d] = vs_acc[d]; vs_acc[d] = 0;
        end
    endtask

    // One clk_sys cycle: drive enables and iRGB (= current HPOS), then check.
    task automatic step(bit c0, bit c1);
        ce0 = c0;
        ce1 = c1;
        irgb0 = 8'(m_p[0] % ht(0));
        irgb1 = 8'(m_p[1] % ht(1));
        @(posedge clk);
        if (c0) model_ce(0, int'(irgb0), int'($signed(hadj0)), int'($signed(vadj0)));
        else begin e_ls[0] = 0; e_fs[0] = 0; end
        if (c1) model_ce(1, int'(irgb1), int'($signed(hadj1)), int'($signed(vadj1)));
        else begin e_ls[1] = 0; e_fs[1] = 0; end
        #1;
        check_vec("d0_outputs", obs_vec(0), exp_vec(0));
        check_vec("d1_outputs", obs_vec(1), exp_vec(1));
        if (c0) meas(0);
        if (c1) meas(1);
    endtask

    task automatic run_ce(int d, int n);
        for (int i = 0; i < n; i++) step(d == 0, d == 1);
    endtask

    task automatic run_until_fs(int d, int bound, string tag);
        bit found;
        found = 0;
        for (int i = 0; i < bound && !found; i++) begin
            step(d == 0, d == 1);
            found = (d == 0) ? fs0 : fs1;
        end
        checki(tag, int'(found), 1);
    endtask

    initial begin
        reset_n = 1'b0;
        ce0 = 0; ce1 = 0;
        hadj0 = 4'd0; vadj0 = 4'd0; hadj1 = 4'd0; vadj1 = 4'd0;
        irgb0 = 8'd0; irgb1 = 8'd0;
        model_reset();
        meas_reset();
        repeat (3) @(posedge clk);
        #1;
        check_vec("reset_d0", obs_vec(0), exp_vec(0));
        check_vec("reset_d1", obs_vec(1), exp_vec(1));
        reset_n = 1'b1;

        // Default geometry, continuous enable, from reset to the first frame strobe.
        run_until_fs(0, 20000, "d0_first_frame_wait");
        checki("d0_first_line_gap", first_gap[0], 128);
        checki("d0_ce_to_first_frame", fs_ce[0], 128 + 38 * 384);
        checki("d0_line_period", gap[0], 384);
        checki("d0_hblk_low_per_line", hb_line[0], 256);
        checki("d0_hsync_fall_hpos", hfall[0], 296);
        checki("d0_hsync_width", hs_len[0], 32);
        checki("d0_vsync_fall_vpos", vfall[0], 227);
        checki("d0_vsync_lines", vs_lines[0], 7);
        checki("d0_frame_cnt", int'(fc0), 1);

        // Small geometry: first partial frame, then a full frame at h_adj = 0.
        run_until_fs(1, 2000, "d1_first_frame_wait");
        checki("d1_first_line_gap", first_gap[1], 16);
        checki("d1_ce_to_first_frame", fs_ce[1], 400);
        run_until_fs(1, 2000, "d1_full_frame_wait");
        checki("d1_lines_per_frame", ln_frame[1], 29);
        checki("d1_de_per_frame", de_frame[1], 640);
        checki("d1_line_period", gap[1], 48);
        checki("d1_hblk_low_per_line", hb_line[1], 32);
        checki("d1_hsync_fall_hpos", hfall[1], 38);
        checki("d1_hsync_width", hs_len[1], 4);
        checki("d1_vsync_fall_vpos", vfall[1], 23);
        checki("d1_vsync_lines", vs_lines[1], 2);

        // Mid-frame adjust change takes effect only from the next frame.
        run_ce(1, 700);
        hadj1 = 4'd5;
        run_until_fs(1, 2000, "d1_adj5_frame_wait");
        checki("d1_no_midframe_move", hfall[1], 38);
        run_ce(1, 100);
        checki("d1_hsync_fall_adj5", hfall[1], 43);

        // Negative adjust clamps the porch at 0.
        hadj1 = 4'b1000;
        vadj1 = 4'b1000;
        run_until_fs(1, 2000, "d1_adjm8_frame_wait");
        run_ce(1, 100);
        checki("d1_hsync_fall_adjm8", hfall[1], 33);
        checki("d1_hsync_width_adjm8", hs_len[1], 4);

        // Positive adjust clamps so the sync still ends inside the line/frame.
        hadj1 = 4'd7;
        vadj1 = 4'd7;
        run_until_fs(1, 2000, "d1_adj7_frame_wait");
        checki("d1_vsync_fall_adjm8", vfall[1], 20);
        checki("d1_vsync_lines_adjm8", vs_lines[1], 2);
        run_ce(1, 100);
        checki("d1_hsync_fall_adj7", hfall[1], 44);
        checki("d1_hsync_width_adj7", hs_len[1], 4);
        run_until_fs(1, 2000, "d1_adj7_frame2_wait");
        checki("d1_vsync_fall_adj7", vfall[1], 26);
        checki("d1_vsync_lines_adj7", vs_lines[1], 2);

        // Enable 1-of-4: outputs hold between enables, oRGB tracks the previous HPOS.
        hadj1 = 4'd0;
        vadj1 = 4'd0;
        for (int i = 0; i < 12000; i++) step(1'b0, (i % 4) == 0);
        checki("d1_de_per_frame_ce4", de_frame[1], 640);
        checki("d1_line_period_ce4", gap[1], 48);

        // Asynchronous reset asserted mid-line in the active area.
        for (int i = 0; i < 2000 && !(hpos1 == 6'd20 && vpos1 == 6'd10); i++) step(1'b0, 1'b1);
        checki("d1_seek_hpos", int'(hpos1), 20);
        checki("d1_seek_vpos", int'(vpos1), 10);
        #2;
        reset_n = 1'b0;
        #1;
        checki("rst_async_hblk", int'(hblk1), 1);
        checki("rst_async_vblk", int'(vblk1), 1);
        checki("rst_async_orgb", int'(orgb1), 0);
        checki("rst_async_de", int'(de1), 0);
        checki("rst_async_hpos", int'(hpos1), 32);
        checki("rst_async_frame_cnt", int'(fc1), 0);
        model_reset();
        meas_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        check_vec("rst_hold_d1", obs_vec(1), exp_vec(1));
        run_until_fs(1, 2000, "d1_post_reset_frame_wait");
        checki("d1_post_reset_line_gap", first_gap[1], 16);
        checki("d1_post_reset_frame_cnt", int'(fc1), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
